// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq
//   Sequential AES-128 key expansion. A start pulse in IDLE registers the
//   cipher key as round key 0. Each round key is then offered downstream with
//   a valid/ready handshake. Every accepted key below round 10 is replaced by
//   the next one, computed combinationally from the registered key, so the
//   block can deliver up to one key per cycle.
//
//   Ports
//     clk        single clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      single-cycle request to expand key_in (ignored while busy
//                and in the cycle that done is high)
//     key_in     128-bit cipher key, w0 = key_in[127:96]
//     rk_ready   downstream accepts round_key this cycle
//     rk_valid   round_key/round_idx valid
//     round_key  current round key, same word order as key_in
//     round_idx  index 0..10 of round_key
//     busy       high while the FSM is not IDLE
//     done       one-cycle pulse after round key 10 is accepted
//     rd_idx     stored-key read index
//     rd_key     stored key at rd_idx (0 when rd_idx > 10 or storage disabled)
//
//   Build option
//     KEY_SCHED_STORE_EN  adds an 11-entry store holding every loaded round
//                         key, read combinationally through rd_idx/rd_key.
//                         Without it rd_key is tied to 0.
module aes_key_schedule_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  input  logic [3:0]   rd_idx,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] rd_key
);

  typedef enum logic {IDLE, RUN} stateT;

  stateT        state, stateNext;
  logic [127:0] keyNext;
  logic [127:0] expandedKey;
  logic [3:0]   idxNext;
  logic         validNext;
  logic         doneNext;
  logic         loadKey;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box computed as affine(x^254); x^254 is the field inverse and maps 0 to 0.
  function automatic logic [7:0] sBox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for the key that follows round index idx.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] nextRoundKey(input logic [127:0] key, input logic [3:0] idx);
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;
    rot = {key[23:0], key[31:24]};
    t   = {sBox(rot[31:24]), sBox(rot[23:16]), sBox(rot[15:8]), sBox(rot[7:0])} ^
          {rcon(idx), 24'h000000};
    w0  = key[127:96] ^ t;
    w1  = key[95:64]  ^ w0;
    w2  = key[63:32]  ^ w1;
    w3  = key[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign expandedKey = nextRoundKey(round_key, round_idx);
  assign busy        = (state != IDLE);

  always_comb begin
    stateNext = state;
    keyNext   = round_key;
    idxNext   = round_idx;
    validNext = rk_valid;
    doneNext  = 1'b0;
    loadKey   = 1'b0;
    case (state)
      IDLE: begin
        // done is high in the first IDLE cycle; a start there is still ignored.
        if (start && !done) begin
          keyNext   = key_in;
          idxNext   = 4'd0;
          validNext = 1'b1;
          loadKey   = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (rk_valid && rk_ready) begin
          if (round_idx < 4'd10) begin
            keyNext = expandedKey;
            idxNext = round_idx + 4'd1;
            loadKey = 1'b1;
          end else begin
            validNext = 1'b0;
            doneNext  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Stage boundary: FSM and round-key registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      round_key <= keyNext;
      round_idx <= idxNext;
      rk_valid  <= validNext;
      done      <= doneNext;
    end
  end

`ifdef KEY_SCHED_STORE_EN
  logic [127:0] keyStore [11];

  // Stage boundary: round-key store, written alongside each key load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) keyStore[i] <= '0;
    end else if (loadKey) begin
      keyStore[idxNext] <= keyNext;
    end
  end

  assign rd_key = (rd_idx <= 4'd10) ? keyStore[rd_idx] : '0;
`else
  logic unusedRdIdx;
  logic unusedLoadKey;
  assign unusedRdIdx   = ^rd_idx;
  assign unusedLoadKey = loadKey;
  assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [3:0]   rd_idx;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [127:0] rd_key;

  int nTests = 0;
  int nFail  = 0;

  logic [127:0] expKeys [11];
  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;

  aes_key_schedule_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .rk_ready(rk_ready), .rd_idx(rd_idx), .rk_valid(rk_valid),
    .round_key(round_key), .round_idx(round_idx), .busy(busy),
    .done(done), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nTests++; if (rk_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid got=%b want=0", rk_valid); end
    nTests++; if (round_key !== 128'h0) begin nFail++; $display("FAIL reset_key got=%h want=0", round_key); end
    nTests++; if (round_idx !== 4'd0) begin nFail++; $display("FAIL reset_idx got=%0d want=0", round_idx); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got=%b want=0", busy); end
    nTests++; if (done !== 1'b0) begin nFail++; $display("FAIL reset_done got=%b want=0", done); end
    nTests++; if (rd_key !== 128'h0) begin nFail++; $display("FAIL reset_rdkey got=%h want=0", rd_key); end
  endtask

  task automatic test_full_expansion();
    rk_ready = 1'b1;
    key_in   = KEY_A;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      nTests++; if (rk_valid !== 1'b1) begin nFail++; $display("FAIL full_valid[%0d] got=%b want=1", i, rk_valid); end
      nTests++; if (round_idx !== 4'(i)) begin nFail++; $display("FAIL full_idx[%0d] got=%0d want=%0d", i, round_idx, i); end
      nTests++; if (round_key !== expKeys[i]) begin nFail++; $display("FAIL full_key[%0d] got=%h want=%h", i, round_key, expKeys[i]); end
      step();
    end
    nTests++; if (done !== 1'b1) begin nFail++; $display("FAIL full_done got=%b want=1", done); end
    nTests++; if (rk_valid !== 1'b0) begin nFail++; $display("FAIL full_end_valid got=%b want=0", rk_valid); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL full_end_busy got=%b want=0", busy); end
    // start during the done cycle must be ignored
    key_in = '1;
    start  = 1'b1;
    step();
    start  = 1'b0;
    key_in = KEY_A;
    nTests++; if (done !== 1'b0) begin nFail++; $display("FAIL done_pulse_len got=%b want=0", done); end
    nTests++; if (rk_valid !== 1'b0) begin nFail++; $display("FAIL start_in_done_valid got=%b want=0", rk_valid); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL start_in_done_busy got=%b want=0", busy); end
  endtask

  task automatic test_store();
    logic [127:0] want10, want0;
`ifdef KEY_SCHED_STORE_EN
    want10 = expKeys[10];
    want0  = expKeys[0];
`else
    want10 = '0;
    want0  = '0;
`endif
    rd_idx = 4'd10; #1;
    nTests++; if (rd_key !== want10) begin nFail++; $display("FAIL store_rd10 got=%h want=%h", rd_key, want10); end
    rd_idx = 4'd12; #1;
    nTests++; if (rd_key !== 128'h0) begin nFail++; $display("FAIL store_rd12 got=%h want=0", rd_key); end
    rd_idx = 4'd0; #1;
    nTests++; if (rd_key !== want0) begin nFail++; $display("FAIL store_rd0 got=%h want=%h", rd_key, want0); end
  endtask

  task automatic test_stall();
    rk_ready = 1'b1;
    key_in   = KEY_A;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    nTests++; if (round_idx !== 4'd3) begin nFail++; $display("FAIL stall_reach_idx got=%0d want=3", round_idx); end
    rk_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      nTests++; if (round_idx !== 4'd3 || round_key !== 128'h3d80477d4716fe3e1e237e446d7a883b || rk_valid !== 1'b1) begin
        nFail++; $display("FAIL stall_hold[%0d] got idx=%0d key=%h vld=%b want idx=3 key=%h vld=1", c, round_idx, round_key, rk_valid, expKeys[3]);
      end
    end
    rk_ready = 1'b1;
    step();
    nTests++; if (round_idx !== 4'd4 || round_key !== expKeys[4]) begin nFail++; $display("FAIL stall_resume got idx=%0d key=%h want idx=4 key=%h", round_idx, round_key, expKeys[4]); end
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      step();
    end
    nTests++; if (done !== 1'b1) begin nFail++; $display("FAIL stall_done got=%b want=1", done); end
    step();
  endtask

  task automatic test_start_ignored();
    rk_ready = 1'b1;
    key_in   = KEY_A;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    nTests++; if (round_idx !== 4'd5 || round_key !== expKeys[5]) begin nFail++; $display("FAIL ign_idx5 got idx=%0d key=%h want idx=5 key=%h", round_idx, round_key, expKeys[5]); end
    key_in = '0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    key_in = KEY_A;
    for (int i = 6; i < 11; i++) begin
      nTests++; if (round_idx !== 4'(i) || round_key !== expKeys[i]) begin nFail++; $display("FAIL ign_seq[%0d] got idx=%0d key=%h want key=%h", i, round_idx, round_key, expKeys[i]); end
      step();
    end
    nTests++; if (done !== 1'b1) begin nFail++; $display("FAIL ign_done got=%b want=1", done); end
    step();
  endtask

  task automatic test_reset_mid();
    rk_ready = 1'b1;
    key_in   = KEY_A;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    nTests++; if (round_idx !== 4'd6) begin nFail++; $display("FAIL rst_mid_reach got=%0d want=6", round_idx); end
    rd_idx = 4'd0;
    rst_n  = 1'b0;
    #1;
    nTests++; if (rk_valid !== 1'b0) begin nFail++; $display("FAIL rst_mid_valid got=%b want=0", rk_valid); end
    nTests++; if (round_key !== 128'h0) begin nFail++; $display("FAIL rst_mid_key got=%h want=0", round_key); end
    nTests++; if (round_idx !== 4'd0) begin nFail++; $display("FAIL rst_mid_idx got=%0d want=0", round_idx); end
    nTests++; if (busy !== 1'b0 || done !== 1'b0) begin nFail++; $display("FAIL rst_mid_ctrl got busy=%b done=%b want 0 0", busy, done); end
    nTests++; if (rd_key !== 128'h0) begin nFail++; $display("FAIL rst_mid_store got=%h want=0", rd_key); end
    step();
    rst_n = 1'b1;
    repeat (2) step();
    nTests++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin nFail++; $display("FAIL rst_mid_idle got vld=%b busy=%b want 0 0", rk_valid, busy); end
    key_in = '0;
    start  = 1'b1;
    step();
    start = 1'b0;
    nTests++; if (round_idx !== 4'd0 || round_key !== 128'h0 || rk_valid !== 1'b1) begin nFail++; $display("FAIL zero_idx0 got idx=%0d key=%h vld=%b want idx=0 key=0 vld=1", round_idx, round_key, rk_valid); end
    step();
    nTests++; if (round_idx !== 4'd1 || round_key !== ZERO_R1) begin nFail++; $display("FAIL zero_idx1 got idx=%0d key=%h want idx=1 key=%h", round_idx, round_key, ZERO_R1); end
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      step();
    end
    nTests++; if (done !== 1'b1) begin nFail++; $display("FAIL zero_done got=%b want=1", done); end
    step();
  endtask

  task automatic test_back_to_back();
    rk_ready = 1'b1;
    key_in   = KEY_A;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      step();
    end
    nTests++; if (done !== 1'b1) begin nFail++; $display("FAIL b2b_done got=%b want=1", done); end
    start = 1'b1;
    step();
    nTests++; if (rk_valid !== 1'b0) begin nFail++; $display("FAIL b2b_ignored got vld=%b want=0", rk_valid); end
    step();
    start = 1'b0;
    nTests++; if (rk_valid !== 1'b1 || round_idx !== 4'd0 || round_key !== KEY_A || busy !== 1'b1) begin
      nFail++; $display("FAIL b2b_restart got vld=%b idx=%0d key=%h busy=%b want vld=1 idx=0 key=%h busy=1", rk_valid, round_idx, round_key, busy, KEY_A);
    end
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      step();
    end
    nTests++; if (done !== 1'b1) begin nFail++; $display("FAIL b2b_done2 got=%b want=1", done); end
    step();
  endtask

  initial begin
    expKeys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expKeys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    expKeys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    expKeys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    expKeys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    expKeys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    expKeys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    expKeys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    expKeys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    expKeys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    expKeys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    rd_idx   = 4'd0;
    repeat (2) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_full_expansion();
    test_store();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_key_schedule_seq.md
AES_KEY_SCHEDULE_SEQ -- requirements
Module: aes_key_schedule_seq

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, single-cycle request to begin expanding key_in.
REQ-004 SHALL have port key_in, input, 128, AES-128 cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
REQ-005 SHALL have port rk_ready, input, 1, downstream round stage accepts the current round key.
REQ-006 SHALL have port rk_valid, output, 1, round_key/round_idx valid.
REQ-007 SHALL have port round_key, output, 128, current round key, same word order as key_in.
REQ-008 SHALL have port round_idx, output, 4, index 0..10 of round_key.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after round key 10 is accepted.
REQ-011 SHALL have ports rd_idx (input, 4) and rd_key (output, 128), stored-key read port (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE and RUN.
REQ-013 IDLE: start=1 SHALL register key_in into round_key, set round_idx=0, set rk_valid=1, enter RUN; first key visible the cycle after start (latency 1).
REQ-014 RUN: handshake occurs in a cycle with rk_valid=1 and rk_ready=1; without a handshake, round_key, round_idx and rk_valid SHALL hold unchanged.
REQ-015 A handshake with round_idx<10 SHALL load the next key: t = SubWord(RotWord(w3)) xor Rcon[round_idx+1]; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'; round_idx increments by 1.
REQ-016 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 in the top byte, 0 in the lower 3 bytes.
REQ-017 SubWord SHALL apply the FIPS-197 forward S-box to each of the 4 bytes; next-key logic is combinational from registered round_key, one key per cycle maximum throughput.
REQ-018 A handshake with round_idx=10 SHALL clear rk_valid, return to IDLE, and assert done for exactly the next cycle.
REQ-019 start SHALL be ignored while busy=1, including the cycle in which done is asserted.
REQ-020 round_idx SHALL never exceed 10; no wrap-around to 0 except via new start from IDLE.
REQ-021 rk_valid SHALL not drop in RUN before its handshake (no withdrawal).

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, rk_valid=0, round_key=0, round_idx=0, busy=0, done=0, and (if enabled) all stored keys to 0.
REQ-023 Reset asserted mid-expansion SHALL abort it; after release the block waits in IDLE for a new start.

Configuration
REQ-024 Macro KEY_SCHED_STORE_EN, when defined, SHALL add an 11x128 register array written with each round key as it is loaded (index = round_idx), readable combinationally as rd_key = array[rd_idx]; rd_idx>10 SHALL return 0.
REQ-025 Without KEY_SCHED_STORE_EN, no array SHALL be built, rd_key SHALL be constant 0 and rd_idx is ignored.

Verification
REQ-026 key_in=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> round_idx 0..10 on 11 consecutive cycles; idx1=a0fafe1788542cb123a339392a6c7605; idx10=d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses 1 cycle after idx10.
REQ-027 Same key, rk_ready=0 for 5 cycles at idx3 -> round_key/round_idx hold at idx3 value 3d80477d4716fe3e1e237e446d7a883b; resumes on rk_ready=1.
REQ-028 Assert start again at idx5 -> ignored; sequence completes unchanged.
REQ-029 Pull rst_n low at idx6 -> all outputs 0 immediately; new start with key 000...0 yields idx1=62636363626363636263636362636363.
REQ-030 With KEY_SCHED_STORE_EN, after REQ-026 completes, rd_idx=10 -> rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx=12 -> 0; without macro rd_key=0.
